input_debounce_pair: RTL

//  Conditioning stage directly upstream of the two-input logic stage (in1/in2 -> out1/out2).

---
 rtl/debounce_pkg.sv | 11 +
 rtl/debounce_channel.sv | 95 +++++++++
 rtl/input_debounce_pair.sv | 52 +++++
 3 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and defaults for the input debounce pair
package debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } db_state_t;

    localparam int DB_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one input: synchroniser, debounce FSM/counter, edge strobes
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   CNT_W           = DB_CNT_W_DEFAULT,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_q, q_d;
    logic                   rise_q, fall_q;

    // Pure shift register: nothing may sit between stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            q_q     <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= q_d & ~q_q;
            fall_q  <= ~q_d & q_q;
        end
    end

    // Any sample that agrees with q drops back to STABLE, restarting the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (s != q_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        q_d = s;
                    end else begin
                        state_d = COUNT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            COUNT: begin
                if (s == q_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    q_d     = s;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/input_debounce_pair.sv
// rtl/input_debounce_pair.sv - two debounced, synchronised inputs with change strobes
module input_debounce_pair
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   CNT_W           = DB_CNT_W_DEFAULT,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_in1,
    input  logic       raw_in2,
    output logic       in1,
    output logic       in2,
    output logic       changed,
    output logic [1:0] rise,
    output logic [1:0] fall
);

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .RESET_VAL       (RESET_VAL)
    ) u_ch1 (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw_in1),
        .q    (in1),
        .rise (rise[0]),
        .fall (fall[0])
    );

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .RESET_VAL       (RESET_VAL)
    ) u_ch2 (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw_in2),
        .q    (in2),
        .rise (rise[1]),
        .fall (fall[1])
    );

    // Strobes are already registered per channel, so this OR stays one cycle wide.
    assign changed = (|rise) | (|fall);

endmodule
